// File: rtl/calc_pkg.sv
// Shared definitions for the calc sequencer: op codes, FSM states and the
// default settle time of the arithmetic unit's combinational datapath.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    localparam int unsigned SETTLE_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StSettle,
        StCapture,
        StDone
    } state_t;

endpackage

// File: rtl/calc_settle_timer.sv
// Settle down-counter: reloaded with SETTLE-1 so that a counting window lasts
// exactly SETTLE cycles, the last of which sees expired high.
module calc_settle_timer
    import calc_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;

    // Reload on load, otherwise count down to zero and hold there
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (count && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer for an external arithmetic unit (AU): loads A and B,
// waits SETTLE cycles for the AU datapath, captures the result and hands it
// back over a valid/ready result channel. Illegal ops and divide-by-zero
// short-circuit to an error result without touching the AU.
// Optional feature: define CALC_CHAIN_EN to add cmd_chain, which substitutes
// the last good result for operand A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned SETTLE = SETTLE_DEFAULT  // must be >= 1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
`ifdef CALC_CHAIN_EN
    input  logic         cmd_chain,
`endif
    output logic [N-1:0] au_in,
    output logic         au_load_a,
    output logic         au_load_b,
    output logic         au_load_r,
    output logic [2:0]   au_op,
    output logic         au_clear,
    input  logic [N-1:0] au_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, b_q;
    logic [2:0]   op_q;
    logic         err_q;
    logic         accept;
    logic         cmd_err;
    logic         settle_done;
    logic         timer_load;
    logic         timer_count;
    logic [N-1:0] a_sel;

    assign accept  = cmd_valid && cmd_ready;
    assign cmd_err = (cmd_op == OP_ILL) || ((cmd_op == OP_DIV) && (cmd_b == '0));

    // AU registers clear together with the sequencer
    assign au_clear = Reset;

`ifdef CALC_CHAIN_EN
    logic [N-1:0] last_q;

    assign a_sel = cmd_chain ? last_q : cmd_a;

    // Remember the last good result for chained commands
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_q <= '0;
        end else if (res_valid && res_ready && !res_err) begin
            last_q <= res_data;
        end
    end
`else
    assign a_sel = cmd_a;
`endif

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the command operands on accept
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            err_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a_sel;
            b_q   <= cmd_b;
            op_q  <= cmd_op;
            err_q <= cmd_err;
        end
    end

    assign timer_load  = (state_q == StLoadB);
    assign timer_count = (state_q == StSettle);

    calc_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (timer_load),
        .count   (timer_count),
        .expired (settle_done)
    );

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        au_in     = '0;
        au_load_a = 1'b0;
        au_load_b = 1'b0;
        au_load_r = 1'b0;
        au_op     = 3'b000;
        res_valid = 1'b0;
        res_data  = '0;
        res_err   = 1'b0;
        busy      = (state_q != StIdle);
        cmd_ready = (state_q == StIdle) && !Reset;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = cmd_err ? StDone : StLoadA;
                end
            end
            StLoadA: begin
                au_in     = a_q;
                au_load_a = 1'b1;
                au_op     = op_q;
                state_d   = StLoadB;
            end
            StLoadB: begin
                au_in     = b_q;
                au_load_b = 1'b1;
                au_op     = op_q;
                state_d   = StSettle;
            end
            StSettle: begin
                au_op = op_q;
                if (settle_done) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                au_load_r = 1'b1;
                au_op     = op_q;
                state_d   = StDone;
            end
            StDone: begin
                res_valid = 1'b1;
                res_err   = err_q;
                res_data  = err_q ? '0 : au_result;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural arithmetic unit
// and a result reference model computed directly from the op-code rules.
`timescale 1ns/1ps
module tb_calc_sequencer;

    localparam int N      = 32;
    localparam int SETTLE = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [2:0]   cmd_op;
`ifdef CALC_CHAIN_EN
    logic         cmd_chain;
`endif
    logic [N-1:0] au_in;
    logic         au_load_a, au_load_b, au_load_r;
    logic [2:0]   au_op;
    logic         au_clear;
    logic [N-1:0] au_result;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_err;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    calc_sequencer #(
        .N      (N),
        .SETTLE (SETTLE)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
`ifdef CALC_CHAIN_EN
        .cmd_chain (cmd_chain),
`endif
        .au_in     (au_in),
        .au_load_a (au_load_a),
        .au_load_b (au_load_b),
        .au_load_r (au_load_r),
        .au_op     (au_op),
        .au_clear  (au_clear),
        .au_result (au_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    // Behavioural arithmetic unit: operand/result registers around a comb ALU
    logic [N-1:0] au_ra, au_rb, au_rr, au_alu;

    always_comb begin
        au_alu = '0;
        case (au_op)
            3'd0: au_alu = au_ra + au_rb;
            3'd1: au_alu = au_ra - au_rb;
            3'd2: au_alu = au_ra * au_rb;
            3'd3: au_alu = (au_rb == '0) ? '0 : au_ra / au_rb;
            3'd4: au_alu = au_ra << au_rb;
            3'd5: au_alu = au_ra >> au_rb;
            3'd6: au_alu = $signed(au_ra) >>> au_rb;
            default: au_alu = '0;
        endcase
    end

    always @(posedge Clock or posedge au_clear) begin
        if (au_clear) begin
            au_ra <= '0;
            au_rb <= '0;
            au_rr <= '0;
        end else begin
            if (au_load_a) au_ra <= au_in;
            if (au_load_b) au_rb <= au_in;
            if (au_load_r) au_rr <= au_alu;
        end
    end

    assign au_result = au_rr;

    // Reference: {err, data} of one command from the op-code rules
    function automatic logic [N:0] ref_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [2:0] op);
        logic [N-1:0] d;
        logic [63:0]  wide;
        logic         e;
        e = (op == 3'd7) || (op == 3'd3 && b == 0);
        d = '0;
        wide = 64'(a) * 64'(b);
        if (!e) begin
            case (op)
                3'd0: d = N'(64'(a) + 64'(b));
                3'd1: d = N'(64'(a) + 64'(~b) + 64'd1);
                3'd2: d = wide[N-1:0];
                3'd3: d = a / b;
                3'd4: d = (b >= N) ? '0 : N'(64'(a) << b);
                3'd5: d = (b >= N) ? '0 : a >> b;
                3'd6: d = (b >= N) ? {N{a[N-1]}} : N'($signed(a) >>> b);
                default: d = '0;
            endcase
        end
        return {e, d};
    endfunction

    // Observations from the last command
    int           o_lat, o_ea, o_eb, o_er, o_na, o_nb, o_nr, o_viol, o_unstable;
    logic         o_post_ok, o_err;
    logic [N-1:0] o_ain, o_bin, o_data;
    logic [2:0]   o_opa, o_opr;
    logic [N-1:0] m_last = '0;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issue one command, track AU strobes per cycle, hold the result for
    // 'hold' cycles, then complete the handshake.
    task automatic do_cmd(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                          input logic chain, input int hold);
        int   guard;
        logic done;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
`ifdef CALC_CHAIN_EN
        cmd_chain = chain;
`else
        if (chain) cmd_a = a;
`endif
        res_ready = 1'b0;
        o_lat = -1; o_ea = 0; o_eb = 0; o_er = 0; o_na = 0; o_nb = 0; o_nr = 0;
        o_viol = 0; o_unstable = 0; o_post_ok = 1'b0; o_err = 1'bx;
        o_ain = 'x; o_bin = 'x; o_data = 'x; o_opa = 'x; o_opr = 'x;
        done = 1'b0;
        step();
        // Scramble inputs after accept: the sequencer must use latched copies
        cmd_valid = 1'b0;
        cmd_a     = $urandom;
        cmd_b     = $urandom;
        cmd_op    = 3'($urandom);
`ifdef CALC_CHAIN_EN
        cmd_chain = 1'($urandom);
`endif
        for (int k = 1; k <= SETTLE + 20 && !done; k++) begin
            if (int'(au_load_a) + int'(au_load_b) + int'(au_load_r) > 1) o_viol++;
            if (!au_load_a && !au_load_b && !au_load_r && au_in !== '0) o_viol++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) o_viol++;
            if (au_load_a) begin o_na++; o_ea = k; o_ain = au_in; o_opa = au_op; end
            if (au_load_b) begin o_nb++; o_eb = k; o_bin = au_in; end
            if (au_load_r) begin o_nr++; o_er = k; o_opr = au_op; end
            if (res_valid === 1'b1) begin
                o_lat  = k;
                o_data = res_data;
                o_err  = res_err;
                done   = 1'b1;
                if (au_op !== 3'b000) o_viol++;
            end else begin
                step();
            end
        end
        if (done) begin
            for (int h = 0; h < hold; h++) begin
                step();
                if (res_valid !== 1'b1 || res_data !== o_data || res_err !== o_err ||
                    cmd_ready !== 1'b0 || busy !== 1'b1 || au_load_a || au_load_b || au_load_r)
                    o_unstable++;
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            o_post_ok = (res_valid === 1'b0 && busy === 1'b0 && cmd_ready === 1'b1);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || res_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b valid=%b err=%b want 0000",
                     cmd_ready, busy, res_valid, res_err);
        end
        n_cmp++;
        if (res_data !== '0 || au_in !== '0 || {au_load_a, au_load_b, au_load_r} !== 3'b000 ||
            au_op !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_data: got data=%h au_in=%h strobes=%b op=%b want zeros",
                     res_data, au_in, {au_load_a, au_load_b, au_load_r}, au_op);
        end
        n_cmp++;
        if (au_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_au_clear: got %b want 1", au_clear);
        end
        step();
        step();
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (au_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_au_clear_release: got %b want 0", au_clear);
        end
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_ready: got ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_add();
        do_cmd(32'd7, 32'd5, 3'b000, 1'b0, 0);
        n_cmp++;
        if (o_lat !== 8) begin
            n_bad++;
            $display("FAIL add_latency: got %0d want 8", o_lat);
        end
        n_cmp++;
        if (o_data !== 32'd12 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL add_result: got data=%0d err=%b want 12 0", o_data, o_err);
        end
        n_cmp++;
        if (o_ea !== 1 || o_eb !== 2 || o_er !== SETTLE + 3 || o_na !== 1 || o_nb !== 1 ||
            o_nr !== 1) begin
            n_bad++;
            $display("FAIL add_strobes: got at %0d/%0d/%0d counts %0d/%0d/%0d want 1/2/%0d 1/1/1",
                     o_ea, o_eb, o_er, o_na, o_nb, o_nr, SETTLE + 3);
        end
        n_cmp++;
        if (o_ain !== 32'd7 || o_bin !== 32'd5 || o_opa !== 3'b000 || o_opr !== 3'b000) begin
            n_bad++;
            $display("FAIL add_au_bus: got a=%0d b=%0d op=%b/%b want 7 5 000/000",
                     o_ain, o_bin, o_opa, o_opr);
        end
        n_cmp++;
        if (o_viol !== 0 || o_post_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL add_protocol: got viol=%0d post_ok=%b want 0 1", o_viol, o_post_ok);
        end
        m_last = 32'd12;
    endtask

    task automatic test_div_zero();
        do_cmd(32'd9, 32'd0, 3'b011, 1'b0, 0);
        n_cmp++;
        if (o_lat !== 1) begin
            n_bad++;
            $display("FAIL div0_latency: got %0d want 1", o_lat);
        end
        n_cmp++;
        if (o_data !== '0 || o_err !== 1'b1) begin
            n_bad++;
            $display("FAIL div0_result: got data=%0d err=%b want 0 1", o_data, o_err);
        end
        n_cmp++;
        if (o_na + o_nb + o_nr !== 0 || o_viol !== 0 || o_post_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL div0_strobes: got strobes=%0d viol=%0d post_ok=%b want 0 0 1",
                     o_na + o_nb + o_nr, o_viol, o_post_ok);
        end
    endtask

    task automatic test_backpressure();
        do_cmd(32'd6, 32'd7, 3'b010, 1'b0, 10);
        n_cmp++;
        if (o_data !== 32'd42 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_result: got data=%0d err=%b want 42 0", o_data, o_err);
        end
        n_cmp++;
        if (o_unstable !== 0 || o_viol !== 0) begin
            n_bad++;
            $display("FAIL bp_stable: got unstable=%0d viol=%0d want 0 0", o_unstable, o_viol);
        end
        n_cmp++;
        if (o_post_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_return_idle: got %b want 1", o_post_ok);
        end
        m_last = 32'd42;
    endtask

    task automatic test_reset_mid();
        int seen;
        while (cmd_ready !== 1'b1) step();
        cmd_valid = 1'b1;
        cmd_a     = 32'd20;
        cmd_b     = 32'd3;
        cmd_op    = 3'b001;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (au_clear !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_during: got clear=%b busy=%b ready=%b valid=%b want 1 0 0 0",
                     au_clear, busy, cmd_ready, res_valid);
        end
        n_cmp++;
        if ({au_load_a, au_load_b, au_load_r} !== 3'b000 || au_op !== 3'b000 || au_in !== '0) begin
            n_bad++;
            $display("FAIL midrst_au: got strobes=%b op=%b in=%h want 000 000 0",
                     {au_load_a, au_load_b, au_load_r}, au_op, au_in);
        end
        step();
        step();
        Reset = 1'b0;
        m_last = '0;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_release: got ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < SETTLE + 8; i++) begin
            if (res_valid !== 1'b0 || au_load_r !== 1'b0) seen++;
            step();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_result: got %0d cycles with result activity want 0", seen);
        end
    endtask

`ifdef CALC_CHAIN_EN
    task automatic test_chain();
        do_cmd(32'd3, 32'd4, 3'b010, 1'b0, 0);
        n_cmp++;
        if (o_data !== 32'd12) begin
            n_bad++;
            $display("FAIL chain_first: got %0d want 12", o_data);
        end
        do_cmd(32'd99, 32'd1, 3'b000, 1'b1, 0);
        n_cmp++;
        if (o_data !== 32'd13 || o_err !== 1'b0 || o_ain !== 32'd12) begin
            n_bad++;
            $display("FAIL chain_result: got data=%0d err=%b a=%0d want 13 0 12",
                     o_data, o_err, o_ain);
        end
        n_cmp++;
        if (!(o_ea < o_eb && o_eb < o_er) || o_na !== 1 || o_nb !== 1 || o_nr !== 1) begin
            n_bad++;
            $display("FAIL chain_strobe_order: got at %0d/%0d/%0d counts %0d/%0d/%0d",
                     o_ea, o_eb, o_er, o_na, o_nb, o_nr);
        end
        m_last = 32'd13;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] a, b, a_eff;
        logic [2:0]   op;
        logic         chain;
        logic [N:0]   exp;
        int           exp_lat, hold, r;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 4);
            b  = (r == 0) ? '0 : (r == 1) ? N'($urandom_range(0, N + 2)) : N'($urandom);
            hold = $urandom_range(0, 3);
            chain = 1'b0;
`ifdef CALC_CHAIN_EN
            chain = 1'($urandom_range(0, 1));
`endif
            a_eff   = chain ? m_last : a;
            exp     = ref_calc(a_eff, b, op);
            exp_lat = exp[N] ? 1 : SETTLE + 4;
            do_cmd(a, b, op, chain, hold);
            n_cmp++;
            if (o_lat !== exp_lat) begin
                n_bad++;
                $display("FAIL rand%0d_latency: got %0d want %0d (op=%0d)", i, o_lat, exp_lat, op);
            end
            n_cmp++;
            if (o_data !== exp[N-1:0] || o_err !== exp[N]) begin
                n_bad++;
                $display("FAIL rand%0d_result: got data=%h err=%b want %h %b (a=%h b=%h op=%0d)",
                         i, o_data, o_err, exp[N-1:0], exp[N], a_eff, b, op);
            end
            n_cmp++;
            if (exp[N] ? (o_na + o_nb + o_nr !== 0)
                       : (o_ea !== 1 || o_eb !== 2 || o_er !== SETTLE + 3 ||
                          o_na !== 1 || o_nb !== 1 || o_nr !== 1)) begin
                n_bad++;
                $display("FAIL rand%0d_strobes: got at %0d/%0d/%0d counts %0d/%0d/%0d err=%b",
                         i, o_ea, o_eb, o_er, o_na, o_nb, o_nr, exp[N]);
            end
            if (!exp[N]) begin
                n_cmp++;
                if (o_ain !== a_eff || o_bin !== b || o_opa !== op || o_opr !== op) begin
                    n_bad++;
                    $display("FAIL rand%0d_au_bus: got a=%h b=%h op=%0d/%0d want %h %h %0d",
                             i, o_ain, o_bin, o_opa, o_opr, a_eff, b, op);
                end
            end
            n_cmp++;
            if (o_viol !== 0 || o_unstable !== 0 || o_post_ok !== 1'b1) begin
                n_bad++;
                $display("FAIL rand%0d_protocol: got viol=%0d unstable=%0d post_ok=%b want 0 0 1",
                         i, o_viol, o_unstable, o_post_ok);
            end
            if (!exp[N]) m_last = exp[N-1:0];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = 3'b000;
        res_ready = 1'b0;
`ifdef CALC_CHAIN_EN
        cmd_chain = 1'b0;
`endif
        test_reset();
        test_add();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
`ifdef CALC_CHAIN_EN
        test_chain();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
